// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// The FSM state encoding also appears on the seq_state debug port.
package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;

  function automatic int clog2_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/pll_seq_sync2.sv
// Two-flop synchroniser for the asynchronous PLL lock flag.
// Both flops clear to 0 under the synchronous active-low reset.
module pll_seq_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer on the 50 MHz reference clock: PLL reset pulse, lock wait, stability, release.
// Optional lock-loss counter port enabled by `define PLL_RESET_SEQ_LOSS_CNT_EN.
module pll_reset_sequencer
  import pll_reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] seq_state
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int TW = clog2_max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMAX     = {TW{1'b1}};
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

  seq_state_t    r_state;
  seq_state_t    w_next_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_retry;
  logic [3:0]    w_next_retry;
  logic          r_pll_rst;
  logic          r_sys_reset_n;
  logic          r_fault;
  logic          w_lock;
  logic          w_restart;

  pll_seq_sync2 u_sync (
    .clk  (refclk),
    .rst_n(rst_n),
    .d    (pll_locked),
    .q    (w_lock)
  );

  // Next-state and retry decode; software request overrides lock/timer events
  always_comb begin
    w_next_state = r_state;
    w_next_retry = r_retry;
    case (r_state)
      RESET_PLL: begin
        if (r_timer == RST_LAST) w_next_state = WAIT_LOCK;
        else                     w_next_state = RESET_PLL;
      end
      WAIT_LOCK: begin
        if (w_lock) begin
          w_next_state = STABLE;
        end else if (r_timer == TO_LAST) begin
          if (r_retry == MAX_R) begin
            w_next_state = FAULT;
          end else begin
            w_next_retry = r_retry + 4'd1;
            w_next_state = RESET_PLL;
          end
        end else begin
          w_next_state = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!w_lock) begin
          w_next_state = WAIT_LOCK;
        end else if (r_timer == STB_LAST) begin
          w_next_state = RUN;
          w_next_retry = 4'd0;
        end else begin
          w_next_state = STABLE;
        end
      end
      RUN: begin
        if (!w_lock) w_next_state = RESET_PLL;
        else         w_next_state = RUN;
      end
      FAULT:   w_next_state = FAULT;
      default: w_next_state = RESET_PLL;
    endcase
    if (sw_reset_req) begin
      w_next_state = RESET_PLL;
      w_next_retry = 4'd0;
    end
  end

  // A software request restarts the timer even when the state encoding is unchanged
  assign w_restart = (w_next_state != r_state) || sw_reset_req;

  // State, timer, retry and output registers (outputs decoded from the next state)
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state       <= RESET_PLL;
      r_timer       <= '0;
      r_retry       <= 4'd0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_timer       <= w_restart ? '0 : ((r_timer == TMAX) ? r_timer : r_timer + 1'b1);
      r_retry       <= w_next_retry;
      r_pll_rst     <= (w_next_state == RESET_PLL) || (w_next_state == FAULT);
      r_sys_reset_n <= (w_next_state == RUN);
      r_fault       <= (w_next_state == FAULT);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_reset_n = r_sys_reset_n;
  assign fault       = r_fault;
  assign retry_cnt   = r_retry;
  assign seq_state   = r_state;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  logic [7:0] r_loss;
  logic       w_loss;

  assign w_loss = (r_state == RUN) && !w_lock;

  // Saturating lock-loss counter; survives software re-sequencing
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_loss <= 8'd0;
    end else if (w_loss && (r_loss != 8'hFF)) begin
      r_loss <= r_loss + 8'd1;
    end else begin
      r_loss <= r_loss;
    end
  end

  assign lock_loss_cnt = r_loss;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with short cycle parameters.
// Expected snapshots {state, pll_rst, sys_reset_n, fault, retry_cnt} are queued per cycle and popped against the DUT.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [2:0] seq_state;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
  logic [7:0] sb_cnt[$];
  logic [7:0] want_cnt;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [9:0] sb[$];
  logic [9:0] got;
  logic [9:0] want;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .seq_state   (seq_state)
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  function automatic logic [9:0] mk(input int st, input bit pr, input bit sr, input bit f, input int rc);
    logic [2:0] s3;
    logic [3:0] r4;
    s3 = 3'(st);
    r4 = 4'(rc);
    return {s3, pr, sr, f, r4};
  endfunction

  function automatic logic [9:0] obs();
    return {seq_state, pll_rst, sys_reset_n, fault, retry_cnt};
  endfunction

  // Lock asserted from cycle 6: visible at cycle 8, STABLE 9..16, RUN from 17
  function automatic logic [9:0] exp_bringup(input int k);
    if (k < 4)       return mk(0, 1'b1, 1'b0, 1'b0, 0);
    else if (k < 9)  return mk(1, 1'b0, 1'b0, 1'b0, 0);
    else if (k < 17) return mk(2, 1'b0, 1'b0, 1'b0, 0);
    else             return mk(3, 1'b0, 1'b1, 1'b0, 0);
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    sw_reset_req = 1'b0;
    pll_locked   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    sw_reset_req = 1'b0;
    pll_locked   = 1'b1;
    for (int n = 0; n < 2; n++) begin
      repeat (4) tick();
      sb.push_back(mk(0, 1'b1, 1'b0, 1'b0, 0));
      got  = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset n=%0d got=%b want=%b", n, got, want);
      end
    end
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    total++;
    if (lock_loss_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_loss_cnt got=%0d want=0", lock_loss_cnt);
    end
`endif
  endtask

  task automatic test_bringup();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      pll_locked = (k >= 6);
      sb.push_back(exp_bringup(k));
      got  = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL bringup k=%0d got=%b want=%b", k, got, want);
      end
      tick();
    end
  endtask

  task automatic test_timeout_fault();
    do_reset();
    for (int k = 0; k < 120; k++) begin
      pll_locked   = 1'b0;
      sw_reset_req = (k == 113);
      if (k < 108) begin
        if ((k % 36) < 4) sb.push_back(mk(0, 1'b1, 1'b0, 1'b0, k / 36));
        else              sb.push_back(mk(1, 1'b0, 1'b0, 1'b0, k / 36));
      end else if (k < 114) begin
        sb.push_back(mk(4, 1'b1, 1'b0, 1'b1, 2));
      end else if (k < 118) begin
        sb.push_back(mk(0, 1'b1, 1'b0, 1'b0, 0));
      end else begin
        sb.push_back(mk(1, 1'b0, 1'b0, 1'b0, 0));
      end
      got  = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL timeout k=%0d got=%b want=%b", k, got, want);
      end
      tick();
    end
    sw_reset_req = 1'b0;
  endtask

  task automatic test_stable_glitch();
    do_reset();
    for (int k = 0; k < 27; k++) begin
      pll_locked = (k >= 6) && (k != 12);
      if (k < 15)       sb.push_back(exp_bringup(k));
      else if (k == 15) sb.push_back(mk(1, 1'b0, 1'b0, 1'b0, 0));
      else if (k < 24)  sb.push_back(mk(2, 1'b0, 1'b0, 1'b0, 0));
      else              sb.push_back(mk(3, 1'b0, 1'b1, 1'b0, 0));
      got  = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL stable_glitch k=%0d got=%b want=%b", k, got, want);
      end
      tick();
    end
  endtask

  task automatic test_run_loss();
    do_reset();
    for (int k = 0; k < 31; k++) begin
      pll_locked = (k >= 6) && (k < 20);
      if (k < 23)      sb.push_back(exp_bringup(k));
      else if (k < 27) sb.push_back(mk(0, 1'b1, 1'b0, 1'b0, 0));
      else             sb.push_back(mk(1, 1'b0, 1'b0, 1'b0, 0));
      got  = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL run_loss k=%0d got=%b want=%b", k, got, want);
      end
      tick();
    end
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    total++;
    if (lock_loss_cnt !== 8'd1) begin
      bad++;
      $display("FAIL run_loss_cnt got=%0d want=1", lock_loss_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int stop_at[2];
    stop_at[0] = 12;
    stop_at[1] = 19;
    for (int n = 0; n < 2; n++) begin
      do_reset();
      for (int k = 0; k < stop_at[n]; k++) begin
        pll_locked = (k >= 6);
        tick();
      end
      sb.push_back(exp_bringup(stop_at[n]));
      got  = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mid_pre n=%0d got=%b want=%b", n, got, want);
      end
      rst_n = 1'b0;
      sb.push_back(mk(0, 1'b1, 1'b0, 1'b0, 0));
      tick();
      got  = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mid n=%0d got=%b want=%b", n, got, want);
      end
      rst_n = 1'b1;
    end
  endtask

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  task automatic test_loss_saturate();
    int  n;
    bool_loop: for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      n = 0;
      while (seq_state !== 3'd3 && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) begin
        total++;
        bad++;
        $display("FAIL loss_sat_run_wait i=%0d state=%0d want=3", i, seq_state);
        break;
      end
      pll_locked = 1'b0;
      sb_cnt.push_back((i + 1 > 255) ? 8'd255 : 8'(i + 1));
      n = 0;
      while (seq_state !== 3'd0 && n < 20) begin
        tick();
        n++;
      end
      want_cnt = sb_cnt.pop_front();
      total++;
      if (n >= 20 || lock_loss_cnt !== want_cnt) begin
        bad++;
        $display("FAIL loss_sat i=%0d got=%0d want=%0d", i, lock_loss_cnt, want_cnt);
      end
    end
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    tick();
    total++;
    if (lock_loss_cnt !== 8'd255 || seq_state !== 3'd0) begin
      bad++;
      $display("FAIL loss_sat_sw got=%0d/%0d want=255/0", lock_loss_cnt, seq_state);
    end
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    test_reset();
    test_bringup();
    test_timeout_fault();
    test_stable_glitch();
    test_run_loss();
    test_reset_mid();
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    do_reset();
    test_loss_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
